// File: rtl/uart_cmd_responder_pkg.sv
// Shared opcodes, reply codes and FSM state type for the UART command responder.
package uart_resp_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W' + addr + data
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R' + addr
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    SEND
  } state_e;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// UART FIFO-side handshake bundle. The responder is the master (pops RX, pushes TX);
// the UART FIFOs are the slave.
interface uart_cmd_responder_if #(
  parameter int DATA_W = 8
);
  logic              rx_empty;
  logic [DATA_W-1:0] r_data;
  logic              incorrect_send;
  logic              rd_uart;
  logic              tx_full;
  logic              wr_uart;
  logic [DATA_W-1:0] w_data;

  modport master (
    input  rx_empty, r_data, incorrect_send, tx_full,
    output rd_uart, wr_uart, w_data
  );

  modport slave (
    output rx_empty, r_data, incorrect_send, tx_full,
    input  rd_uart, wr_uart, w_data
  );
endinterface

// File: rtl/uart_cmd_responder_regfile.sv
// Small byte register file: one synchronous write port, one combinational read port,
// and the whole array exported flat (byte i at [i*DATA_W +: DATA_W]).
module uart_resp_regfile #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                                 clk,
  input  logic                                 Reset,
  input  logic                                 we,
  input  logic [REG_ADDR_W-1:0]                waddr,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [REG_ADDR_W-1:0]                raddr,
  output logic [DATA_W-1:0]                    rdata,
  output logic [DATA_W*(2**REG_ADDR_W)-1:0]    regs_out
);

  localparam int NREGS = 2**REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  // Next-state of the array: copy, then overlay the single write.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Register the array; it must read back as all zeros after reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      // NOTE: this array is reset explicitly because readers observe it straight after reset;
      // large RAMs normally skip reset so they can map to memory macros.
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      mem_q <= mem_d;
    end
  end

  // Combinational read port and flat export.
  always_comb begin
    rdata    = mem_q[raddr];
    regs_out = '0;
    for (int i = 0; i < NREGS; i++) regs_out[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// UART command responder: pops command bytes from the UART RX FIFO, executes
// 'W' addr data / 'R' addr against a byte register file, and pushes one reply byte
// (ACK, NAK or read data) to the UART TX FIFO.
// Optional feature: define UART_RESP_TIMEOUT_EN to abort a command that stalls
// for TIMEOUT_CY idle cycles between bytes (timeout pulses, no reply).
module uart_cmd_responder
  import uart_resp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
`ifdef UART_RESP_TIMEOUT_EN
  , parameter int TIMEOUT_CY = 1000
`endif
) (
  input  logic                              clk,
  input  logic                              Reset,
  uart_cmd_responder_if.master              uart,
  output logic [DATA_W*(2**REG_ADDR_W)-1:0] regs_out,
  output logic                              busy,
  output logic [7:0]                        cmd_count,
  output logic                              timeout
);

  state_e                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [REG_ADDR_W-1:0]   addr_q, addr_d;
  logic                    addr_ok_q, addr_ok_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       reply_q, reply_d;
  logic [7:0]              cmd_count_q, cmd_count_d;
  logic                    timeout_q, timeout_d;

  logic                    pop;
  logic                    push;
  logic                    err_now;
  logic                    rx_addr_ok;
  logic                    reg_we;
  logic [DATA_W-1:0]       reg_rdata;

`ifdef UART_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CY + 1);
  logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
`endif

  // Strobes are combinational and forced low while reset is asserted.
  assign pop         = Reset && (state_q != SEND) && !uart.rx_empty;
  assign push        = Reset && (state_q == SEND) && !uart.tx_full;
  assign uart.rd_uart = pop;
  assign uart.wr_uart = push;
  assign uart.w_data  = reply_q;
  assign busy        = (state_q != IDLE);
  assign cmd_count   = cmd_count_q;
  assign timeout     = timeout_q;

  // A parity error arriving with the final byte still belongs to this command.
  assign err_now    = err_q | (uart.incorrect_send && (state_q != SEND));
  assign rx_addr_ok = ((uart.r_data >> REG_ADDR_W) == '0);

  uart_resp_regfile #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .Reset    (Reset),
    .we       (reg_we),
    .waddr    (addr_q),
    .wdata    (uart.r_data),
    .raddr    (uart.r_data[REG_ADDR_W-1:0]),
    .rdata    (reg_rdata),
    .regs_out (regs_out)
  );

  // Command parser: next state, captured fields, reply byte and register write.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    addr_ok_d   = addr_ok_q;
    err_d       = err_now;
    reply_d     = reply_q;
    cmd_count_d = cmd_count_q;
    timeout_d   = 1'b0;
    reg_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          if (uart.r_data == DATA_W'(OP_WRITE) || uart.r_data == DATA_W'(OP_READ)) begin
            is_write_d = (uart.r_data == DATA_W'(OP_WRITE));
            state_d    = GET_ADDR;
          end else begin
            reply_d = DATA_W'(RSP_NAK);
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (pop) begin
          addr_d    = uart.r_data[REG_ADDR_W-1:0];
          addr_ok_d = rx_addr_ok;
          if (is_write_q) begin
            state_d = GET_DATA;
          end else begin
            reply_d = (err_now || !rx_addr_ok) ? DATA_W'(RSP_NAK) : reg_rdata;
            state_d = SEND;
          end
        end
      end
      GET_DATA: begin
        if (pop) begin
          if (!err_now && addr_ok_q) begin
            reg_we  = 1'b1;
            reply_d = DATA_W'(RSP_ACK);
          end else begin
            reply_d = DATA_W'(RSP_NAK);
          end
          state_d = SEND;
        end
      end
      SEND: begin
        if (push) begin
          state_d     = IDLE;
          err_d       = 1'b0;
          cmd_count_d = cmd_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_RESP_TIMEOUT_EN
    // Idle-cycle counter between bytes; any pop or leaving the byte states clears it.
    tmo_cnt_d = '0;
    if ((state_q == GET_ADDR || state_q == GET_DATA) && uart.rx_empty) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CY - 1)) begin
        state_d   = IDLE;
        err_d     = 1'b0;
        timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      addr_ok_q   <= 1'b0;
      err_q       <= 1'b0;
      reply_q     <= '0;
      cmd_count_q <= '0;
      timeout_q   <= 1'b0;
`ifdef UART_RESP_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      addr_ok_q   <= addr_ok_d;
      err_q       <= err_d;
      reply_q     <= reply_d;
      cmd_count_q <= cmd_count_d;
      timeout_q   <= timeout_d;
`ifdef UART_RESP_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder. A command-level model (register array,
// expected-reply queue, reply counter) predicts every pushed byte; a compare process
// checks pushes, strobe gating and the timeout output on every cycle.
module tb_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        Reset;
  logic [63:0] regs_out;
  logic        busy;
  logic [7:0]  cmd_count;
  logic        timeout;

  uart_cmd_responder_if #(.DATA_W(8)) bus ();

  uart_cmd_responder dut (
    .clk       (clk),
    .Reset     (Reset),
    .uart      (bus),
    .regs_out  (regs_out),
    .busy      (busy),
    .cmd_count (cmd_count),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Command-level model.
  logic [7:0] m_regs [8];
  int         m_count = 0;
  logic [7:0] exp_q [$];
  int         push_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  // Predict the reply and register effect of one complete command.
  task automatic expect_cmd(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input bit err);
    logic [7:0] r;
    if (op != 8'h57 && op != 8'h52)  r = 8'h15;
    else if (err || addr > 8'd7)     r = 8'h15;
    else if (op == 8'h57) begin
      m_regs[addr[2:0]] = data;
      r = 8'h06;
    end else                         r = m_regs[addr[2:0]];
    exp_q.push_back(r);
    m_count = (m_count + 1) % 256;
  endtask

  // Present one byte on the RX FIFO head and wait (bounded) for it to be popped.
  task automatic feed_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_empty = 1'b0;
    bus.r_data   = b;
    #1;
    while (!bus.rd_uart && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pop", {63'b0, bus.rd_uart}, 64'd1);
    @(posedge clk);
    #1;
    bus.rx_empty = 1'b1;
  endtask

  task automatic pulse_perr();
    @(negedge clk);
    bus.incorrect_send = 1'b1;
    @(negedge clk);
    bus.incorrect_send = 1'b0;
  endtask

  // Wait (bounded) until the responder is idle and all predicted replies came out.
  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    check("idle_busy", {63'b0, busy}, 64'd0);
    check("reply_outstanding", exp_q.size(), 64'd0);
    exp_q.delete();
    check("regs", regs_out, model_flat());
    check("count", cmd_count, m_count);
  endtask

  // Per-cycle compare: pushes against the model, strobe gating, timeout.
  always @(negedge clk) begin
    #2;
    if (!Reset) begin
      check("rd_gated", {63'b0, bus.rd_uart}, 64'd0);
      check("wr_gated", {63'b0, bus.wr_uart}, 64'd0);
    end else if (bus.tx_full) begin
      check("wr_blocked", {63'b0, bus.wr_uart}, 64'd0);
    end else if (bus.wr_uart) begin
      push_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_push: got %h expected no push", bus.w_data);
      end else begin
        check("reply", bus.w_data, exp_q.pop_front());
      end
    end
`ifndef UART_RESP_TIMEOUT_EN
    check("timeout_low", {63'b0, timeout}, 64'd0);
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    Reset              = 1'b0;
    bus.rx_empty       = 1'b0;   // head valid during reset: pop must stay gated
    bus.r_data         = 8'h57;
    bus.incorrect_send = 1'b0;
    bus.tx_full        = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_regs", regs_out, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_count", cmd_count, 64'd0);
    check("rst_timeout", {63'b0, timeout}, 64'd0);
    check("rst_wdata", bus.w_data, 64'd0);
    check("rst_rd", {63'b0, bus.rd_uart}, 64'd0);
    bus.rx_empty = 1'b1;
    @(negedge clk);
    Reset = 1'b1;

    // 1: write 0xA5 to reg 3, ACK one cycle after the last pop.
    expect_cmd(8'h57, 8'h03, 8'hA5, 1'b0);
    feed_byte(8'h57);
    feed_byte(8'h03);
    feed_byte(8'hA5);
    @(negedge clk);
    #3;
    check("t1_push", {63'b0, bus.wr_uart}, 64'd1);
    check("t1_wdata", bus.w_data, 64'h06);
    wait_idle();
    check("t1_reg3", regs_out[31:24], 64'hA5);
    check("t1_count", cmd_count, 64'd1);

    // 2: read reg 3 back.
    expect_cmd(8'h52, 8'h03, 8'h00, 1'b0);
    feed_byte(8'h52);
    feed_byte(8'h03);
    @(negedge clk);
    #3;
    check("t2_wdata", bus.w_data, 64'hA5);
    wait_idle();
    check("t2_regs", regs_out, 64'h00000000_A5000000);
    check("t2_count", cmd_count, 64'd2);

    // 3: unknown opcode NAKs at once; following bytes form a fresh read.
    expect_cmd(8'h41, 8'h00, 8'h00, 1'b0);
    expect_cmd(8'h52, 8'h00, 8'h00, 1'b0);
    feed_byte(8'h41);
    feed_byte(8'h52);
    feed_byte(8'h00);
    wait_idle();

    // 4: out-of-range write consumes all 3 bytes, NAK; reply held by tx_full.
    expect_cmd(8'h57, 8'h08, 8'hFF, 1'b0);
    @(negedge clk);
    bus.tx_full = 1'b1;
    feed_byte(8'h57);
    feed_byte(8'h08);
    feed_byte(8'hFF);
    p0 = push_seen;
    repeat (20) @(negedge clk);
    #3;
    check("t4_hold_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    bus.tx_full = 1'b0;
    wait_idle();
    check("t4_one_push", push_seen - p0, 64'd1);
    check("t4_regs_zero_low", regs_out[23:0], 64'd0);

    // 5a: set reg 1, then a write with a parity error mid-command is refused.
    expect_cmd(8'h57, 8'h01, 8'h11, 1'b0);
    feed_byte(8'h57);
    feed_byte(8'h01);
    feed_byte(8'h11);
    wait_idle();
    expect_cmd(8'h57, 8'h01, 8'h33, 1'b1);
    feed_byte(8'h57);
    feed_byte(8'h01);
    pulse_perr();
    feed_byte(8'h33);
    wait_idle();
    check("t5_reg1", regs_out[15:8], 64'h11);

    // 5b: reset mid-command discards it and clears everything.
    feed_byte(8'h57);
    feed_byte(8'h01);
    @(negedge clk);
    Reset        = 1'b0;
    bus.rx_empty = 1'b0;
    bus.r_data   = 8'h52;
    @(negedge clk);
    #3;
    check("t5_rst_busy", {63'b0, busy}, 64'd0);
    check("t5_rst_regs", regs_out, 64'd0);
    bus.rx_empty = 1'b1;
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_count = 0;
    expect_cmd(8'h52, 8'h01, 8'h00, 1'b0);
    feed_byte(8'h52);
    feed_byte(8'h01);
    wait_idle();
    check("t5_count", cmd_count, 64'd1);

    // 6: stalled command after a lone opcode byte.
    p0 = push_seen;
    feed_byte(8'h57);
`ifdef UART_RESP_TIMEOUT_EN
    n = 0;
    @(negedge clk);
    #2;
    while (!timeout && n < 1100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_timeout_seen", {63'b0, timeout}, 64'd1);
    wait_idle();
    check("t6_no_push", push_seen - p0, 64'd0);
    expect_cmd(8'h52, 8'h00, 8'h00, 1'b0);
    feed_byte(8'h52);
    feed_byte(8'h00);
    wait_idle();
`else
    n = 0;
    repeat (1200) @(negedge clk);
    #3;
    check("t6_still_busy", {63'b0, busy}, 64'd1);
    check("t6_no_push", push_seen - p0, 64'd0);
    expect_cmd(8'h57, 8'h00, 8'h5A, 1'b0);
    feed_byte(8'h00);
    feed_byte(8'h5A);
    wait_idle();
    check("t6_reg0", regs_out[7:0], 64'h5A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
